// File: rtl/mem_arb_pkg.sv
// Shared state encodings and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefLineW = 256;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one data memory between icache (m0) and dcache (m1), holding ownership while enabled.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise m1 wins every tie.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned LINE_W = DefLineW
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [LINE_W-1:0] m0_data_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    output logic [LINE_W-1:0] m0_data_o,
    output logic              m0_ack_o,

    input  logic [LINE_W-1:0] m1_data_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    output logic [LINE_W-1:0] m1_data_o,
    output logic              m1_ack_o,

    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic [1:0]        grant_o
);

    arb_state_e state_q;
    logic [1:0] grant_q;
    logic       pick0;
    logic       pick1;

`ifdef ARB_RR_EN
    // 1 when m1 was the most recent owner, so m0 wins the first tie out of reset.
    logic last_q;

    always_comb begin
        pick0 = m0_enable_i & (~m1_enable_i | last_q);
        pick1 = m1_enable_i & ~pick0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= 1'b1;
        end else if (state_q == StIdle && (pick0 || pick1)) begin
            last_q <= pick1;
        end
    end
`else
    always_comb begin
        pick1 = m1_enable_i;
        pick0 = m0_enable_i & ~m1_enable_i;
    end
`endif

    // Owners always return through StIdle, leaving one idle cycle between grants.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick0) begin
                        state_q <= StOwn0;
                        grant_q <= 2'b01;
                    end else if (pick1) begin
                        state_q <= StOwn1;
                        grant_q <= 2'b10;
                    end
                end
                StOwn0: begin
                    if (!m0_enable_i) begin
                        state_q <= StIdle;
                        grant_q <= 2'b00;
                    end
                end
                StOwn1: begin
                    if (!m1_enable_i) begin
                        state_q <= StIdle;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        mem_data_o   = '0;
        mem_addr_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        case (state_q)
            StOwn0: begin
                mem_data_o   = m0_data_i;
                mem_addr_o   = m0_addr_i;
                mem_enable_o = m0_enable_i;
                mem_write_o  = m0_write_i;
            end
            StOwn1: begin
                mem_data_o   = m1_data_i;
                mem_addr_o   = m1_addr_i;
                mem_enable_o = m1_enable_i;
                mem_write_o  = m1_write_i;
            end
            default: ;
        endcase
    end

    assign m0_ack_o  = mem_ack_i & (state_q == StOwn0);
    assign m1_ack_o  = mem_ack_i & (state_q == StOwn1);
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;
    assign grant_o   = grant_q;

endmodule
